// File: rtl/index_address_generator.sv
// 65C02 indexed effective-address generator: zp,X/Y; abs,X/Y; (zp,X); (zp),Y.
// Sequences the zero-page pointer reads and the high-byte fixup cycle, then strobes the result.
module index_address_generator #(
    parameter logic [7:0] ZP_PAGE     = 8'h00,
    parameter bit         WRITE_FIXUP = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic        write_op_i,
    input  logic [7:0]  index_in_i,
    input  logic        abort_i,
    input  logic [7:0]  db_in_i,
    input  logic        db_valid_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] ea_o,
    output logic        ea_valid_o,
    output logic        page_cross_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle, StOpLo, StOpHi, StPtrLo, StPtrHi, StAdd, StFixup, StDone
    } state_e;

    localparam logic [1:0] ModeZp    = 2'b00;
    localparam logic [1:0] ModeAbs   = 2'b01;
    localparam logic [1:0] ModeIndX  = 2'b10;
    localparam logic [1:0] ModeIndY  = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic        wr_q, wr_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  base_lo_q, base_lo_d;
    logic [7:0]  base_hi_q, base_hi_d;
    logic [15:0] ea_q, ea_d;
    logic        page_cross_q, page_cross_d;

    logic [7:0]  db_idx_sum;
    logic [8:0]  add_sum;
    logic [7:0]  ptr_inc;

    assign db_idx_sum = db_in_i + idx_q;
    assign add_sum    = {1'b0, base_lo_q} + {1'b0, idx_q};
    assign ptr_inc    = ptr_q + 8'd1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            mode_q       <= 2'b00;
            wr_q         <= 1'b0;
            idx_q        <= 8'h00;
            ptr_q        <= 8'h00;
            base_lo_q    <= 8'h00;
            base_hi_q    <= 8'h00;
            ea_q         <= 16'h0000;
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            base_lo_q    <= base_lo_d;
            base_hi_q    <= base_hi_d;
            ea_q         <= ea_d;
            page_cross_q <= page_cross_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        base_lo_d    = base_lo_q;
        base_hi_d    = base_hi_q;
        ea_d         = ea_q;
        page_cross_d = page_cross_q;

        // Abort wins over any byte arriving in the same cycle.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_d       = mode_i;
                        wr_d         = write_op_i;
                        idx_d        = index_in_i;
                        page_cross_d = 1'b0;
                        state_d      = StOpLo;
                    end
                end
                StOpLo: begin
                    if (db_valid_i) begin
                        unique case (mode_q)
                            ModeZp: begin
                                ea_d    = {ZP_PAGE, db_idx_sum};
                                state_d = StDone;
                            end
                            ModeAbs: begin
                                base_lo_d = db_in_i;
                                state_d   = StOpHi;
                            end
                            ModeIndX: begin
                                ptr_d   = db_idx_sum;
                                state_d = StPtrLo;
                            end
                            ModeIndY: begin
                                ptr_d   = db_in_i;
                                state_d = StPtrLo;
                            end
                        endcase
                    end
                end
                StOpHi: begin
                    if (db_valid_i) begin
                        base_hi_d = db_in_i;
                        state_d   = StAdd;
                    end
                end
                StPtrLo: begin
                    if (db_valid_i) begin
                        base_lo_d = db_in_i;
                        state_d   = StPtrHi;
                    end
                end
                StPtrHi: begin
                    if (db_valid_i) begin
                        base_hi_d = db_in_i;
                        if (mode_q == ModeIndX) begin
                            ea_d    = {db_in_i, base_lo_q};
                            state_d = StDone;
                        end else begin
                            state_d = StAdd;
                        end
                    end
                end
                StAdd: begin
                    ea_d[7:0]    = add_sum[7:0];
                    page_cross_d = add_sum[8];
                    if (add_sum[8] || (WRITE_FIXUP && wr_q)) begin
                        state_d = StFixup;
                    end else begin
                        ea_d[15:8] = base_hi_q;
                        state_d    = StDone;
                    end
                end
                StFixup: begin
                    ea_d[15:8] = base_hi_q + {7'd0, page_cross_q};
                    state_d    = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr_o = 16'h0000;
        if (state_q == StPtrLo) begin
            mem_addr_o = {ZP_PAGE, ptr_q};
        end else if (state_q == StPtrHi) begin
            mem_addr_o = {ZP_PAGE, ptr_inc};
        end
    end

    assign mem_req_o    = (state_q == StPtrLo) || (state_q == StPtrHi);
    assign ea_o         = ea_q;
    assign ea_valid_o   = (state_q == StDone);
    assign page_cross_o = page_cross_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_index_address_generator.sv
// Bench for index_address_generator: vector table with a scoreboard queue, plus reset,
// abort and held-start sequences. Inputs change and outputs are sampled on the falling edge.
module tb_index_address_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic        write_op;
    logic [7:0]  index_in;
    logic        abort;
    logic [7:0]  db_in;
    logic        db_valid;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] ea;
    logic        ea_valid;
    logic        page_cross;
    logic        busy;

    index_address_generator #(
        .ZP_PAGE    (8'h00),
        .WRITE_FIXUP(1'b1)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .mode_i      (mode),
        .write_op_i  (write_op),
        .index_in_i  (index_in),
        .abort_i     (abort),
        .db_in_i     (db_in),
        .db_valid_i  (db_valid),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .ea_o        (ea),
        .ea_valid_o  (ea_valid),
        .page_cross_o(page_cross),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic        wr;
        logic [7:0]  idx;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [15:0] ea;
        logic        pc;
        int          lat;
        int          nptr;
        logic [15:0] a0;
        logic [15:0] a1;
    } vec_t;

    typedef struct packed {
        logic [15:0] ea;
        logic        pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected_ea_valid: got 1, expected 0", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, " ea"}, {16'h0, ea}, {16'h0, e.ea});
            check({tag, " page_cross"}, {31'h0, page_cross}, {31'h0, e.pc});
        end
    endtask

    task automatic apply_vec(input vec_t v, input int n);
        logic [7:0]  bytes[3];
        logic [15:0] addrs[2];
        int          lat;
        int          naddr;
        string       tag;
        bytes = '{v.b0, v.b1, v.b2};
        addrs = '{16'hxxxx, 16'hxxxx};
        lat   = -1;
        naddr = 0;
        tag   = $sformatf("vec%0d", n);
        @(negedge clk);
        start    = 1'b1;
        mode     = v.mode;
        write_op = v.wr;
        index_in = v.idx;
        db_valid = 1'b0;
        sb_q.push_back('{ea: v.ea, pc: v.pc});
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            start    = 1'b0;
            index_in = 8'($urandom);
            if (k == 1) check({tag, " busy"}, {31'h0, busy}, 32'h1);
            if (mem_req) begin
                if (naddr < 2) addrs[naddr] = mem_addr;
                naddr++;
            end
            if (ea_valid) begin
                lat = k;
                sb_pop_compare(tag);
            end
            db_in    = (k <= 3) ? bytes[k-1] : 8'($urandom);
            db_valid = 1'b1;
        end
        if (lat < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " ptr_reads"}, 32'(naddr), 32'(v.nptr));
        if (v.nptr == 2) begin
            check({tag, " ptr_addr0"}, {16'h0, addrs[0]}, {16'h0, v.a0});
            check({tag, " ptr_addr1"}, {16'h0, addrs[1]}, {16'h0, v.a1});
        end
        @(negedge clk);
        db_valid = 1'b0;
        check({tag, " pulse_end"}, {30'h0, ea_valid, busy}, 32'h0);
        check({tag, " ea_held"}, {16'h0, ea}, {16'h0, v.ea});
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        vecs[0] = '{2'd0, 1'b0, 8'h20, 8'hF0, 8'h00, 8'h00, 16'h0010, 1'b0, 2, 0, 16'h0, 16'h0};
        vecs[1] = '{2'd1, 1'b0, 8'h20, 8'hF0, 8'h12, 8'h00, 16'h1310, 1'b1, 5, 0, 16'h0, 16'h0};
        vecs[2] = '{2'd1, 1'b0, 8'h05, 8'h00, 8'h12, 8'h00, 16'h1205, 1'b0, 4, 0, 16'h0, 16'h0};
        vecs[3] = '{2'd1, 1'b1, 8'h05, 8'h00, 8'h12, 8'h00, 16'h1205, 1'b0, 5, 0, 16'h0, 16'h0};
        vecs[4] = '{2'd2, 1'b0, 8'h01, 8'hFE, 8'h34, 8'h12, 16'h1234, 1'b0, 4, 2, 16'h00FF, 16'h0000};
        vecs[5] = '{2'd3, 1'b0, 8'h01, 8'h80, 8'hFF, 8'hFF, 16'h0000, 1'b1, 6, 2, 16'h0080, 16'h0081};
        vecs[6] = '{2'd3, 1'b0, 8'h10, 8'h40, 8'h00, 8'h20, 16'h2010, 1'b0, 5, 2, 16'h0040, 16'h0041};
        vecs[7] = '{2'd3, 1'b1, 8'h10, 8'h40, 8'h00, 8'h20, 16'h2010, 1'b0, 6, 2, 16'h0040, 16'h0041};
        vecs[8] = '{2'd0, 1'b0, 8'hFF, 8'h02, 8'h00, 8'h00, 16'h0001, 1'b0, 2, 0, 16'h0, 16'h0};
        vecs[9] = '{2'd1, 1'b0, 8'h20, 8'hF0, 8'hFF, 8'h00, 16'h0010, 1'b1, 5, 0, 16'h0, 16'h0};

        reset = 1'b1; start = 1'b0; mode = 2'b00; write_op = 1'b0; index_in = 8'h00;
        abort = 1'b0; db_in = 8'h00; db_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst ea", {16'h0, ea}, 32'h0);
        check("rst flags", {28'h0, ea_valid, page_cross, mem_req, busy}, 32'h0);
        check("rst mem_addr", {16'h0, mem_addr}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

        // Asynchronous reset while in the fixup cycle of abs,Y $12F0+$20.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; write_op = 1'b0; index_in = 8'h20; db_valid = 1'b0;
        @(negedge clk); start = 1'b0; db_in = 8'hF0; db_valid = 1'b1;
        @(negedge clk); db_in = 8'h12;
        @(negedge clk); db_valid = 1'b0;
        @(negedge clk);
        check("fixup busy", {31'h0, busy}, 32'h1);
        check("fixup ea_lo", {24'h0, ea[7:0]}, 32'h10);
        #2 reset = 1'b1;
        #1;
        check("async_rst ea", {16'h0, ea}, 32'h0);
        check("async_rst flags", {28'h0, ea_valid, page_cross, mem_req, busy}, 32'h0);
        @(negedge clk); reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ea_valid) pulses++;
        end
        check("async_rst no_pulse", 32'(pulses), 32'h0);

        // Abort in PTR_HI together with db_valid.
        @(negedge clk);
        start = 1'b1; mode = 2'd2; write_op = 1'b0; index_in = 8'h01; db_valid = 1'b0;
        @(negedge clk); start = 1'b0; db_in = 8'hFE; db_valid = 1'b1;
        @(negedge clk); db_in = 8'h34;
        @(negedge clk);
        check("abort ptr_hi addr", {15'h0, mem_req, mem_addr}, {15'h0, 1'b1, 16'h0000});
        db_in = 8'h12; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; db_valid = 1'b0;
        check("abort idle", {30'h0, ea_valid, busy}, 32'h0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ea_valid) pulses++;
        end
        check("abort no_pulse", 32'(pulses), 32'h0);

        // start held through DONE: accepted only in IDLE cycles 0, 3, 6.
        pulses = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k > 0) begin
                if (ea_valid) begin
                    pulses++;
                    check("held_start pulse_cycle", 32'(k % 3), 32'h2);
                    sb_pop_compare("held_start");
                end
                if (k == 3 || k == 6) check("held_start idle", {31'h0, busy}, 32'h0);
            end
            if (k <= 6) begin
                start = 1'b1; mode = 2'd0; write_op = 1'b0; index_in = 8'h20;
                if (k % 3 == 0) sb_q.push_back('{ea: 16'h0010, pc: 1'b0});
            end else begin
                start = 1'b0;
            end
            db_in = 8'hF0; db_valid = 1'b1;
        end
        db_valid = 1'b0;
        check("held_start pulses", 32'(pulses), 32'h3);
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/index_address_generator.md
Name: index_address_generator

Overview:
- Consumer of the X/Y index register outputs: forms 65C02 indexed effective addresses (zp,X/Y; abs,X/Y; (zp,X); (zp),Y) from operand bytes on the internal data bus plus a sampled index value.
- Sequences zero-page pointer reads for the indirect modes, detects page crossing, and inserts the high-byte fixup cycle.
- Hands the finished 16-bit effective address to the bus/address-high/low logic with a one-cycle valid strobe.

Parameters:
- ZP_PAGE, 8'h00: high byte used for zero-page results and pointer reads.
- WRITE_FIXUP, 1: when 1, abs/(zp),Y write ops always take the fixup cycle, even with no page cross.

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces the reset state immediately.
- start  input  1  begin a calculation; sampled only in IDLE.
- mode  input  2  00 zp-indexed, 01 abs-indexed, 10 (zp,X), 11 (zp),Y; sampled with start.
- write_op  input  1  current instruction is a store/RMW (rwb low at execute); sampled with start.
- index_in  input  8  X or Y register value; sampled with start.
- abort  input  1  synchronous cancel; return to IDLE, no ea_valid.
- db_in  input  8  data bus byte (operand or pointer byte).
- db_valid  input  1  db_in holds the byte the current state is waiting for.
- mem_req  output  1  pointer read request; high throughout PTR_LO/PTR_HI.
- mem_addr  output  16  pointer read address; {ZP_PAGE, ptr} in PTR_LO, {ZP_PAGE, ptr+1 mod 256} in PTR_HI, else 0.
- ea  output  16  effective address; valid while ea_valid is high, holds last value otherwise.
- ea_valid  output  1  single-cycle pulse in DONE.
- page_cross  output  1  base_lo + index carried; updated in ADD, held until next start.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; ea=16'h0000, ea_valid=0, page_cross=0, mem_req=0, mem_addr=0, busy=0; internal base/ptr/index registers cleared. Reset in any state, including mid-fixup, aborts without ea_valid.
- IDLE: on start, latch mode, write_op and index_in; clear page_cross; go to OP_LO.
  - Later changes to index_in (e.g. X incrementing) are ignored until the next start.
- OP_LO: wait for db_valid, then act by mode:
  - zp: ea={ZP_PAGE, (db_in+idx) mod 256}, go to DONE. No page cross ever; the high byte never changes.
  - abs: base_lo=db_in, go to OP_HI.
  - (zp,X): ptr=(db_in+idx) mod 256, go to PTR_LO.
  - (zp),Y: ptr=db_in, go to PTR_LO.
- OP_HI: on db_valid, base_hi=db_in, go to ADD.
- PTR_LO: on db_valid, base_lo=db_in, go to PTR_HI.
- PTR_HI: on db_valid, base_hi=db_in. Pointer address wraps inside the zero page (ptr=FF reads FF then 00).
  - (zp,X): ea={base_hi, base_lo}, go to DONE. No index add, no page_cross.
  - (zp),Y: go to ADD.
- ADD: 9-bit sum = base_lo + idx; ea_lo=sum[7:0]; page_cross=sum[8].
  - Go to FIXUP if sum[8], or if (WRITE_FIXUP and write_op).
  - Otherwise ea_hi=base_hi and go to DONE.
- FIXUP: ea_hi=(base_hi+page_cross) mod 256, so $FFxx wraps to $00xx; go to DONE.
- DONE: ea_valid=1 for exactly one cycle, busy still 1; next state IDLE. start asserted during DONE is ignored.
- db_valid outside OP_LO/OP_HI/PTR_LO/PTR_HI is ignored.
- Waiting states stall indefinitely without db_valid.
- abort has priority over db_valid in the same cycle.
- Minimum latency from the start cycle to ea_valid, with db_valid present every cycle:
  - zp: 2 cycles.
  - abs: 4 cycles (5 with fixup).
  - (zp,X): 4 cycles.
  - (zp),Y: 5 cycles (6 with fixup).

Test Plan:
- zp,X: start, mode=00, index=8'h20, operand 8'hF0 -> ea=16'h0010, page_cross=0, ea_valid exactly 2 cycles after start.
- abs,Y read: index=8'h20, operand 8'hF0 then 8'h12 -> ADD then FIXUP, ea=16'h1310, page_cross=1, 5-cycle latency. Same with base 16'h1200, index 8'h05 -> ea=16'h1205, no fixup, 4 cycles. With write_op=1 -> fixup taken, ea=16'h1205, page_cross=0, 5 cycles.
- (zp,X): operand 8'hFE, index 8'h01 -> mem_addr 16'h00FF then 16'h0000 (wrap); db 8'h34, 8'h12 -> ea=16'h1234, page_cross=0.
- (zp),Y wrap: pointer at 8'h80 returns 8'hFF, 8'hFF; index 8'h01 -> ea=16'h0000, page_cross=1; index_in changed mid-op has no effect.
- Reset asserted asynchronously during FIXUP -> outputs return to reset values immediately, no ea_valid pulse. Separately, abort in PTR_HI together with db_valid -> IDLE, no ea_valid.
- start held high through DONE -> exactly one ea_valid per accepted start; new op begins only from IDLE.
